// File: rtl/register_pkg.sv
// Shared definitions for the general-purpose storage register:
// default width and the operation decoded from the e/l/w controls.
package register_pkg;

  localparam int REG_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_SHL  = 2'd2,
    OP_ROL  = 2'd3
  } reg_op_e;

  // Enable dominates; load dominates the shift/rotate selection.
  function automatic reg_op_e decode_op(input logic e, input logic l, input logic w);
    reg_op_e op;
    if (!e) begin
      op = OP_HOLD;
    end else if (l) begin
      op = OP_LOAD;
    end else if (w) begin
      op = OP_ROL;
    end else begin
      op = OP_SHL;
    end
    return op;
  endfunction

endpackage

// File: rtl/register.sv
// Holdable, loadable word with in-place one-bit shift-left / rotate-left.
// q is driven straight from the state flops.
module register
  import register_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r,
  input  logic             l,
  input  logic             e,
  input  logic             w,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] shifted;
  reg_op_e          op;

  // Bit 0 receives the old MSB on rotate and zero on a logical shift.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shifted[gi] = w & q_reg[WIDTH-1];
      end else begin : g_upper
        assign shifted[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    op     = decode_op(e, l, w);
    case (op)
      OP_LOAD: q_next = r;
      OP_SHL,
      OP_ROL:  q_next = shifted;
      default: q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

  a_enable_known: assert property (@(posedge clk) rst_n |-> !$isunknown(e));

endmodule

// File: tb/tb_register.sv
// Directed bench for the storage register: reset, load, hold, shift/rotate
// at the MSB boundary, full-circle rotate/shift and reset priority.
module tb_register;
  import register_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] r;
  logic         l;
  logic         e;
  logic         w;
  logic [W-1:0] q;

  int checks;
  int errors;
  int op_bins [4];

  register #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .r     (r),
    .l     (l),
    .e     (e),
    .w     (w),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge with the currently driven inputs; returns 1 ns after it.
  task automatic cycle();
    reg_op_e op;
    op = decode_op(e, l, w);
    if (rst_n) op_bins[op]++;
    @(posedge clk);
    #1;
    $display("txn rst_n=%0b op=%s r=%h q=%h", rst_n, rst_n ? op.name() : "RESET", r, q);
  endtask

  task automatic do_load(input logic [W-1:0] val);
    e = 1'b1; l = 1'b1; w = 1'b0; r = val;
    cycle();
  endtask

  task automatic do_shift(input logic wrap);
    e = 1'b1; l = 1'b0; w = wrap; r = 32'h5555_5555;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; e = 1'b1; l = 1'b1; w = 1'b0; r = 32'hFFFF_FFFF;
    cycle();
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL reset: q=%h expected %h", q, 32'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    do_load(32'h0000_0005);
    checks++;
    if (q !== 32'h0000_0005) begin
      errors++;
      $display("FAIL load: q=%h expected %h", q, 32'h0000_0005);
    end
    do_shift(1'b0);
    checks++;
    if (q !== 32'h0000_000A) begin
      errors++;
      $display("FAIL load_then_shift: q=%h expected %h", q, 32'h0000_000A);
    end
    // w must be ignored while loading
    e = 1'b1; l = 1'b1; w = 1'b1; r = 32'h0000_0003;
    cycle();
    checks++;
    if (q !== 32'h0000_0003) begin
      errors++;
      $display("FAIL load_w_ignored: q=%h expected %h", q, 32'h0000_0003);
    end
  endtask

  task automatic test_hold();
    do_load(32'hDEAD_BEEF);
    checks++;
    if (q !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hold_load: q=%h expected %h", q, 32'hDEAD_BEEF);
    end
    for (int i = 0; i < 3; i++) begin
      e = 1'b0; r = 32'h0; l = i[0]; w = ~i[0];
      cycle();
      checks++;
      if (q !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL hold_%0d: q=%h expected %h", i, q, 32'hDEAD_BEEF);
      end
    end
  endtask

  task automatic test_msb_boundary();
    do_load(32'h8000_0001);
    do_shift(1'b0);
    checks++;
    if (q !== 32'h0000_0002) begin
      errors++;
      $display("FAIL shl_msb: q=%h expected %h", q, 32'h0000_0002);
    end
    do_load(32'h8000_0001);
    do_shift(1'b1);
    checks++;
    if (q !== 32'h0000_0003) begin
      errors++;
      $display("FAIL rol_msb: q=%h expected %h", q, 32'h0000_0003);
    end
  endtask

  task automatic test_full_circle();
    do_load(32'h1234_5678);
    do_shift(1'b1);
    checks++;
    if (q !== 32'h2468_ACF0) begin
      errors++;
      $display("FAIL rol_first: q=%h expected %h", q, 32'h2468_ACF0);
    end
    for (int i = 1; i < W; i++) do_shift(1'b1);
    checks++;
    if (q !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rol_32: q=%h expected %h", q, 32'h1234_5678);
    end
    for (int i = 0; i < 16; i++) do_shift(1'b0);
    checks++;
    if (q !== 32'h5678_0000) begin
      errors++;
      $display("FAIL shl_16: q=%h expected %h", q, 32'h5678_0000);
    end
    for (int i = 16; i < W; i++) do_shift(1'b0);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL shl_32: q=%h expected %h", q, 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    do_load(32'h0F0F_0F0F);
    rst_n = 1'b0; e = 1'b1; l = 1'b1; w = 1'b0; r = 32'hA5A5_A5A5;
    cycle();
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL reset_priority: q=%h expected %h", q, 32'h0);
    end
    rst_n = 1'b1;
    do_load(32'hA5A5_A5A5);
    checks++;
    if (q !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL reload_after_reset: q=%h expected %h", q, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_back_to_back();
    do_load(32'hC000_0000);
    do_shift(1'b1);
    checks++;
    if (q !== 32'h8000_0001) begin
      errors++;
      $display("FAIL b2b_rol1: q=%h expected %h", q, 32'h8000_0001);
    end
    do_shift(1'b1);
    checks++;
    if (q !== 32'h0000_0003) begin
      errors++;
      $display("FAIL b2b_rol2: q=%h expected %h", q, 32'h0000_0003);
    end
    do_load(32'h0000_00F0);
    do_shift(1'b0);
    checks++;
    if (q !== 32'h0000_01E0) begin
      errors++;
      $display("FAIL b2b_load_shl: q=%h expected %h", q, 32'h0000_01E0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    foreach (op_bins[i]) op_bins[i] = 0;
    rst_n = 1'b1; e = 1'b0; l = 1'b0; w = 1'b0; r = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_hold();
    test_msb_boundary();
    test_full_circle();
    test_reset_priority();
    test_back_to_back();
    $display("coverage hold=%0d load=%0d shl=%0d rol=%0d",
             op_bins[OP_HOLD], op_bins[OP_LOAD], op_bins[OP_SHL], op_bins[OP_ROL]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
